axis_fifo_pkt: RTL

- Parametrised AXI4-Stream synchronous FIFO with full backpressure: `s_axis_tready` on the slave side, plus fill-level and almost-full status.
- Carries tdata, tkeep and tlast per beat.
- Sits between stream producers and consumers in the AXIS datapath, clocked by the shared stream clock.
- Optionally compiled as a store-and-forward packet FIFO that presents a packet only once its last beat has arrived.

---
 rtl/axis_fifo_pkt.sv | 62 ++++++
 1 files changed

// File: rtl/axis_fifo_pkt.sv
// axis_fifo_pkt: AXI4-Stream first-word-fall-through FIFO with fill level and almost-full status.
// Define AXIS_FIFO_PKT_MODE_EN to hold each packet back until its tlast beat is stored.
module axis_fifo_pkt #(
   parameter int data_bits       = 8,
   parameter int mem_depth       = 16,
   parameter int tkeep_width     = data_bits / 8,
   parameter int almost_full_thr = mem_depth - 2
) (
   input  logic                       axis_clk,
   input  logic                       axis_resetn,
   input  logic [data_bits-1:0]       s_axis_tdata,
   input  logic [tkeep_width-1:0]     s_axis_tkeep,
   input  logic                       s_axis_tlast,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   output logic [data_bits-1:0]       m_axis_tdata,
   output logic [tkeep_width-1:0]     m_axis_tkeep,
   output logic                       m_axis_tlast,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic [$clog2(mem_depth):0] fill_count,
   output logic                       almost_full
);
   localparam int aw = $clog2(mem_depth);
   localparam int pw = aw + 1;
   localparam int ew = data_bits + tkeep_width + 1;
   localparam logic [aw:0] c_af_thr = pw'(almost_full_thr);
   logic [ew-1:0] r_mem [mem_depth];
   logic [aw:0]   r_wr_ptr, r_rd_ptr;
   logic          w_empty, w_full, w_wr, w_rd;
   assign w_empty       = r_wr_ptr == r_rd_ptr;
   assign w_full        = (r_wr_ptr[aw-1:0] == r_rd_ptr[aw-1:0]) && (r_wr_ptr[aw] != r_rd_ptr[aw]);
   assign s_axis_tready = axis_resetn && !w_full;
   assign w_wr          = s_axis_tvalid && s_axis_tready;
   assign w_rd          = m_axis_tvalid && m_axis_tready;
   assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = r_mem[r_rd_ptr[aw-1:0]];
   assign fill_count    = r_wr_ptr - r_rd_ptr;
   assign almost_full   = fill_count >= c_af_thr;
   always_ff @(posedge axis_clk)
      if (w_wr) r_mem[r_wr_ptr[aw-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
   always_ff @(posedge axis_clk or negedge axis_resetn)
      if (!axis_resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + pw'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + pw'(1);
      end
`ifdef AXIS_FIFO_PKT_MODE_EN
   logic [aw:0] r_pkt_cnt;
   logic        w_last_in, w_last_out;
   assign w_last_in  = w_wr && s_axis_tlast;
   assign w_last_out = w_rd && m_axis_tlast;
   // A full FIFO with no complete packet would deadlock, so it streams cut-through instead.
   assign m_axis_tvalid = !w_empty && (r_pkt_cnt != '0 || w_full);
   always_ff @(posedge axis_clk or negedge axis_resetn)
      if (!axis_resetn) r_pkt_cnt <= '0;
      else r_pkt_cnt <= r_pkt_cnt + pw'(w_last_in) - pw'(w_last_out);
`else
   assign m_axis_tvalid = !w_empty;
`endif
endmodule
